sync_fifo_flagged: RTL and testbench

SYNC_FIFO_FLAGGED -- requirements
Module: sync_fifo_flagged

---
 rtl/sync_fifo_flagged.sv | 146 ++++++++++++++
 tb/tb_sync_fifo_flagged.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flagged.sv
// Synchronous single-clock FIFO with status flags, sticky error flags,
// flush, chip select and a selectable standard / first-word-fall-through
// read port.
module sync_fifo_flagged #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cs,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          rd_valid,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);
    localparam logic             IS_FWFT = (FWFT != 0);

    // Storage is deliberately left out of reset; the pointers hide stale words.
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      count_q,  count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] head_word;

    // Status decoded from the registered pointers only.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    assign wr_accept = cs & wr_en & ~full;
    assign rd_accept = cs & rd_en & ~empty;
    assign head_word = mem_q[rd_ptr_q[ADDR_W-1:0]];

    assign count        = count_q;
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // In FWFT mode the head word is presented directly while data is stored;
    // when empty the last captured word is shown instead.
    assign data_out = (IS_FWFT && !empty) ? head_word : data_out_q;
    assign rd_valid = rd_valid_q | (IS_FWFT & ~empty);

    // Next-state computation for pointers, count, read port and sticky flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            // Flush discards contents but keeps what the reader last saw.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            if (IS_FWFT && !empty) begin
                data_out_d = head_word;
            end
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                data_out_d = head_word;
                rd_valid_d = ~IS_FWFT;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + PTR_W'(1);
                2'b01:   count_d = count_q - PTR_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Setting has priority over a coincident clear.
        if (cs && wr_en && full) begin
            overflow_d = 1'b1;
        end else if (cs && clr_err) begin
            overflow_d = 1'b0;
        end
        if (cs && rd_en && empty) begin
            underflow_d = 1'b1;
        end else if (cs && clr_err) begin
            underflow_d = 1'b0;
        end
    end

    // Control and read-port registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory write port; flush and reset suppress the write.
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_accept) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
`timescale 1ns/1ps
// Directed testbench for sync_fifo_flagged: a standard-mode instance and an
// FWFT instance, each scenario in its own task.
module tb_sync_fifo_flagged;

    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Standard-mode instance signals
    logic          rst, cs, flush, wr_en, rd_en, clr_err;
    logic [DW-1:0] data_in, data_out;
    logic          rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0]    count;

    // FWFT instance signals
    logic          f_rst, f_cs, f_flush, f_wr_en, f_rd_en, f_clr_err;
    logic [DW-1:0] f_data_in, f_data_out;
    logic          f_rd_valid, f_empty, f_full, f_almost_empty, f_almost_full, f_overflow, f_underflow;
    logic [4:0]    f_count;

    int n_cmp = 0;
    int n_err = 0;

    sync_fifo_flagged #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .cs(cs), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .clr_err(clr_err), .data_out(data_out), .rd_valid(rd_valid),
        .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_flagged #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(f_rst), .cs(f_cs), .flush(f_flush), .wr_en(f_wr_en), .data_in(f_data_in),
        .rd_en(f_rd_en), .clr_err(f_clr_err), .data_out(f_data_out), .rd_valid(f_rd_valid),
        .empty(f_empty), .full(f_full), .almost_empty(f_almost_empty), .almost_full(f_almost_full),
        .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr_en = 1'b1; rd_en = 1'b0; data_in = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop;
        rd_en = 1'b1; wr_en = 1'b0;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; f_rst = 1'b1; wr_en = 1'b1; data_in = 32'h1234; clr_err = 1'b1;
        tick();
        rst = 1'b0; f_rst = 1'b0; wr_en = 1'b0; clr_err = 1'b0;
        if ({empty, full, almost_empty, almost_full, rd_valid, overflow, underflow} !== 7'b1010000) begin
            $display("FAIL reset_flags: got %b want 1010000", {empty, full, almost_empty, almost_full, rd_valid, overflow, underflow}); n_err++;
        end
        n_cmp++;
        if (count !== 5'd0) begin $display("FAIL reset_count: got %0d want 0", count); n_err++; end
        n_cmp++;
        if (data_out !== 32'h0) begin $display("FAIL reset_data: got %h want 0", data_out); n_err++; end
        n_cmp++;
        if ({f_empty, f_rd_valid, f_count} !== {1'b1, 1'b0, 5'd0}) begin
            $display("FAIL reset_fwft: got e=%b v=%b c=%0d want e=1 v=0 c=0", f_empty, f_rd_valid, f_count); n_err++;
        end
        n_cmp++;
        $display("reset done");
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < 16; i++) begin
            push(DW'(i));
            if (count !== 5'(i + 1)) begin $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); n_err++; end
            n_cmp++;
            if ({full, almost_full, almost_empty, empty} !== {(i == 15), (i + 1 >= 14), (i + 1 <= 2), 1'b0}) begin
                $display("FAIL fill_flags[%0d]: got %b want %b", i, {full, almost_full, almost_empty, empty},
                         {(i == 15), (i + 1 >= 14), (i + 1 <= 2), 1'b0}); n_err++;
            end
            n_cmp++;
            $display("write %0d count=%0d full=%b af=%b", i, count, full, almost_full);
        end
        for (int i = 0; i < 16; i++) begin
            pop();
            if (data_out !== DW'(i) || rd_valid !== 1'b1) begin
                $display("FAIL drain_data[%0d]: got %h v=%b want %h v=1", i, data_out, rd_valid, i); n_err++;
            end
            n_cmp++;
            if (count !== 5'(15 - i) || empty !== (i == 15)) begin
                $display("FAIL drain_count[%0d]: got %0d e=%b want %0d e=%b", i, count, empty, 15 - i, (i == 15)); n_err++;
            end
            n_cmp++;
            $display("read %0d data=%h count=%0d", i, data_out, count);
        end
        tick();
        if (rd_valid !== 1'b0) begin $display("FAIL rd_valid_pulse: got %b want 0", rd_valid); n_err++; end
        n_cmp++;
    endtask

    task automatic test_overflow_underflow;
        for (int i = 0; i < 16; i++) push(32'h100 + DW'(i));
        push(32'hDEAD);
        if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
            $display("FAIL overflow_set: got ov=%b c=%0d f=%b want ov=1 c=16 f=1", overflow, count, full); n_err++;
        end
        n_cmp++;
        $display("overflow write ov=%b count=%0d", overflow, count);
        for (int i = 0; i < 16; i++) begin
            pop();
            if (data_out !== 32'h100 + DW'(i)) begin
                $display("FAIL overflow_drain[%0d]: got %h want %h", i, data_out, 32'h100 + i); n_err++;
            end
            n_cmp++;
        end
        pop();
        if (underflow !== 1'b1 || data_out !== 32'h10F || rd_valid !== 1'b0) begin
            $display("FAIL underflow_set: got un=%b d=%h v=%b want un=1 d=10f v=0", underflow, data_out, rd_valid); n_err++;
        end
        n_cmp++;
        $display("underflow read un=%b data=%h", underflow, data_out);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        if ({overflow, underflow} !== 2'b00) begin
            $display("FAIL clr_err: got %b want 00", {overflow, underflow}); n_err++;
        end
        n_cmp++;
        $display("clr_err ov=%b un=%b", overflow, underflow);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 5; i++) push(32'h200 + DW'(i));
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; data_in = 32'h205 + DW'(k);
            tick();
            if (count !== 5'd5 || data_out !== 32'h200 + DW'(k) || rd_valid !== 1'b1) begin
                $display("FAIL b2b[%0d]: got c=%0d d=%h v=%b want c=5 d=%h v=1", k, count, data_out, rd_valid, 32'h200 + k); n_err++;
            end
            n_cmp++;
            $display("b2b %0d data=%h count=%0d", k, data_out, count);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            pop();
            if (data_out !== 32'h214 + DW'(j)) begin
                $display("FAIL b2b_drain[%0d]: got %h want %h", j, data_out, 32'h214 + j); n_err++;
            end
            n_cmp++;
        end
        if (empty !== 1'b1) begin $display("FAIL b2b_empty: got %b want 1", empty); n_err++; end
        n_cmp++;
        // Full with both requests: only the read is taken.
        for (int i = 0; i < 16; i++) push(32'h300 + DW'(i));
        wr_en = 1'b1; rd_en = 1'b1; data_in = 32'h3FF;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        if (count !== 5'd15 || data_out !== 32'h300 || overflow !== 1'b1) begin
            $display("FAIL full_both: got c=%0d d=%h ov=%b want c=15 d=300 ov=1", count, data_out, overflow); n_err++;
        end
        n_cmp++;
        $display("full both count=%0d data=%h", count, data_out);
        for (int i = 1; i < 16; i++) begin
            pop();
            if (data_out !== 32'h300 + DW'(i)) begin
                $display("FAIL full_both_drain[%0d]: got %h want %h", i, data_out, 32'h300 + i); n_err++;
            end
            n_cmp++;
        end
        // Empty with both requests: only the write is taken, no write-through.
        wr_en = 1'b1; rd_en = 1'b1; data_in = 32'h400;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        if (count !== 5'd1 || rd_valid !== 1'b0 || data_out !== 32'h30F || underflow !== 1'b1) begin
            $display("FAIL empty_both: got c=%0d v=%b d=%h un=%b want c=1 v=0 d=30f un=1", count, rd_valid, data_out, underflow); n_err++;
        end
        n_cmp++;
        $display("empty both count=%0d data=%h", count, data_out);
        pop();
        if (data_out !== 32'h400) begin $display("FAIL empty_both_word: got %h want 400", data_out); n_err++; end
        n_cmp++;
        clr_err = 1'b1; tick(); clr_err = 1'b0;
    endtask

    task automatic test_chip_select;
        for (int i = 0; i < 3; i++) push(32'h500 + DW'(i));
        cs = 1'b0; wr_en = 1'b1; rd_en = 1'b1; data_in = 32'h5FF;
        tick(); tick();
        if (count !== 5'd3 || rd_valid !== 1'b0 || data_out !== 32'h400 || {overflow, underflow} !== 2'b00) begin
            $display("FAIL cs_idle: got c=%0d v=%b d=%h err=%b want c=3 v=0 d=400 err=00", count, rd_valid, data_out, {overflow, underflow}); n_err++;
        end
        n_cmp++;
        $display("cs=0 count=%0d", count);
        cs = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 3; i < 16; i++) push(32'h500 + DW'(i));
        cs = 1'b0; wr_en = 1'b1;
        tick();
        if (overflow !== 1'b0 || count !== 5'd16) begin
            $display("FAIL cs_full: got ov=%b c=%0d want ov=0 c=16", overflow, count); n_err++;
        end
        n_cmp++;
        cs = 1'b1; tick(); wr_en = 1'b0;
        cs = 1'b0; clr_err = 1'b1; tick();
        if (overflow !== 1'b1) begin $display("FAIL cs_clr_ignored: got %b want 1", overflow); n_err++; end
        n_cmp++;
        cs = 1'b1; tick(); clr_err = 1'b0;
        if (overflow !== 1'b0) begin $display("FAIL cs_clr: got %b want 0", overflow); n_err++; end
        n_cmp++;
        $display("cs clr ov=%b", overflow);
    endtask

    task automatic test_flush_reset;
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 10; i++) push(32'h600 + DW'(i));
        pop();
        if (count !== 5'd9 || data_out !== 32'h600) begin
            $display("FAIL pre_flush: got c=%0d d=%h want c=9 d=600", count, data_out); n_err++;
        end
        n_cmp++;
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 32'h6FF;
        tick();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        if (count !== 5'd0 || empty !== 1'b1 || data_out !== 32'h600 || rd_valid !== 1'b0) begin
            $display("FAIL flush: got c=%0d e=%b d=%h v=%b want c=0 e=1 d=600 v=0", count, empty, data_out, rd_valid); n_err++;
        end
        n_cmp++;
        $display("flush count=%0d data=%h", count, data_out);
        for (int i = 0; i < 3; i++) push(32'h700 + DW'(i));
        if (count !== 5'd3) begin $display("FAIL refill: got %0d want 3", count); n_err++; end
        n_cmp++;
        rst = 1'b1; flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        if ({empty, full, almost_empty, almost_full, rd_valid, overflow, underflow} !== 7'b1010000 ||
            count !== 5'd0 || data_out !== 32'h0) begin
            $display("FAIL mid_reset: got flags=%b c=%0d d=%h want 1010000 c=0 d=0",
                     {empty, full, almost_empty, almost_full, rd_valid, overflow, underflow}, count, data_out); n_err++;
        end
        n_cmp++;
        $display("mid reset count=%0d data=%h", count, data_out);
    endtask

    task automatic test_fwft;
        f_wr_en = 1'b1; f_data_in = 32'hA5;
        tick();
        f_data_in = 32'h5A;
        if (f_data_out !== 32'hA5 || f_empty !== 1'b0 || f_rd_valid !== 1'b1) begin
            $display("FAIL fwft_first: got d=%h e=%b v=%b want d=a5 e=0 v=1", f_data_out, f_empty, f_rd_valid); n_err++;
        end
        n_cmp++;
        $display("fwft write a5 data=%h", f_data_out);
        tick();
        f_wr_en = 1'b0;
        if (f_data_out !== 32'hA5 || f_count !== 5'd2) begin
            $display("FAIL fwft_hold: got d=%h c=%0d want d=a5 c=2", f_data_out, f_count); n_err++;
        end
        n_cmp++;
        f_rd_en = 1'b1; tick();
        if (f_data_out !== 32'h5A || f_count !== 5'd1) begin
            $display("FAIL fwft_next: got d=%h c=%0d want d=5a c=1", f_data_out, f_count); n_err++;
        end
        n_cmp++;
        $display("fwft read data=%h", f_data_out);
        tick(); f_rd_en = 1'b0;
        if (f_empty !== 1'b1 || f_rd_valid !== 1'b0 || f_count !== 5'd0) begin
            $display("FAIL fwft_empty: got e=%b v=%b c=%0d want e=1 v=0 c=0", f_empty, f_rd_valid, f_count); n_err++;
        end
        n_cmp++;
        $display("fwft drained empty=%b", f_empty);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;
        f_rst = 1'b1; f_cs = 1'b1; f_flush = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_data_in = '0;
        tick();
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_back_to_back();
        test_chip_select();
        test_flush_reset();
        test_fwft();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
